// File: rtl/alarm_pkg.sv
// Shared constants and helpers for the alarm trigger block: the "no alarm"
// setpoint code, FSM state encodings and the countdown width helper.
package alarm_pkg;

  // Setpoint hours value meaning "no alarm set"
  localparam logic [4:0] NO_ALARM = 5'd24;

  // Upper bound (exclusive) for a valid minutes value
  localparam logic [5:0] MINUTES_PER_HOUR = 6'd60;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ARMED  = 3'd1;
  localparam state_t ST_RING   = 3'd2;
  localparam state_t ST_SNOOZE = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;

  // Countdown width wide enough for the larger of the two durations
  function automatic int cnt_width(input int ring_secs, input int snooze_secs);
    int max_secs;
    max_secs = (ring_secs > snooze_secs) ? ring_secs : snooze_secs;
    return (max_secs < 2) ? 1 : $clog2(max_secs);
  endfunction

endpackage

// File: rtl/alarm_trigger_sec_countdown.sv
// Saturating seconds countdown shared by the RING and SNOOZE phases.
// A load takes priority over a tick; once at zero the value stays at zero.
module sec_countdown #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick_sec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, or decrement on a second tick without wrapping below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick_sec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares the running time against the alarm setpoint,
// rings, handles stop/snooze/auto-timeout and drives the buzzer outputs.
// A setpoint hours value of 24 means no alarm and aborts any event.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_sec,
  input  logic       real_quarter,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       stop,
  input  logic       snooze,
  output logic       ringing,
  output logic       buzz,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);

  localparam int              CNT_W        = cnt_width(RING_SECS, SNOOZE_SECS);
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS - 1);
  localparam logic [1:0]      MAX_SNOOZE_C = 2'(MAX_SNOOZE);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       snooze_cnt_q;
  logic [1:0]       snooze_cnt_d;
  logic             ringing_q;
  logic             ringing_d;
  logic             snoozing_q;
  logic             snoozing_d;
  logic             match_s;
  logic             alarm_valid_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic             cnt_zero_s;

  // Out-of-range setpoints (hours 24..31, minutes 60..63) can never fire
  assign alarm_valid_s = (alarm_hours < NO_ALARM) && (alarm_minutes < MINUTES_PER_HOUR);
  assign match_s       = alarm_valid_s
                         && (cur_hours == alarm_hours)
                         && (cur_minutes == alarm_minutes)
                         && (cur_seconds == 6'd0);

  sec_countdown #(
    .W (CNT_W)
  ) u_countdown (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .tick_sec (tick_sec),
    .zero     (cnt_zero_s)
  );

  // State and snooze-count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      snooze_cnt_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      snooze_cnt_q <= snooze_cnt_d;
    end
  end

  // Next-state logic; a cleared setpoint overrides every other request
  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    if (alarm_hours == NO_ALARM) begin
      state_d      = ST_IDLE;
      snooze_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (tick_sec && match_s) begin
            state_d = ST_RING;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_RING: begin
          if (stop) begin
            state_d = ST_HOLD;
          end else if (snooze) begin
            if (snooze_cnt_q < MAX_SNOOZE_C) begin
              state_d      = ST_SNOOZE;
              snooze_cnt_d = snooze_cnt_q + 2'd1;
            end else begin
              state_d = ST_HOLD;
            end
          end else if (tick_sec && cnt_zero_s) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_RING;
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            state_d = ST_HOLD;
          end else if (tick_sec && cnt_zero_s) begin
            state_d = ST_RING;
          end else begin
            state_d = ST_SNOOZE;
          end
        end
        ST_HOLD: begin
          // Stay put while still inside the matching second so it cannot re-fire
          if (!match_s) begin
            state_d      = ST_ARMED;
            snooze_cnt_d = 2'd0;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          snooze_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // Output decode and countdown reload on entry to RING or SNOOZE
  always_comb begin
    ringing_d  = (state_d == ST_RING);
    snoozing_d = (state_d == ST_SNOOZE);
    cnt_load_s = (state_d != state_q) && ((state_d == ST_RING) || (state_d == ST_SNOOZE));
    if (state_d == ST_SNOOZE) begin
      cnt_load_val_s = SNOOZE_LOAD;
    end else begin
      cnt_load_val_s = RING_LOAD;
    end
  end

  // Registered status outputs, aligned with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign snooze_cnt = snooze_cnt_q;
  assign buzz       = ringing_q & real_quarter;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed self-checking bench for alarm_trigger.
module tb_alarm_trigger;
  import alarm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_sec;
  logic       real_quarter;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       stop;
  logic       snooze;
  logic       ringing;
  logic       buzz;
  logic       snoozing;
  logic [1:0] snooze_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  alarm_trigger dut (
    .clk           (clk),
    .reset         (reset),
    .tick_sec      (tick_sec),
    .real_quarter  (real_quarter),
    .cur_hours     (cur_hours),
    .cur_minutes   (cur_minutes),
    .cur_seconds   (cur_seconds),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .stop          (stop),
    .snooze        (snooze),
    .ringing       (ringing),
    .buzz          (buzz),
    .snoozing      (snoozing),
    .snooze_cnt    (snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick_sec = 1'b1;
    step();
    tick_sec = 1'b0;
    step();
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hours   = h;
    cur_minutes = m;
    cur_seconds = s;
  endtask

  task automatic check_outs(input string tag, input logic r, input logic sz, input logic [1:0] cnt);
    check({tag, ".ringing"}, 32'(ringing), 32'(r));
    check({tag, ".snoozing"}, 32'(snoozing), 32'(sz));
    check({tag, ".snooze_cnt"}, 32'(snooze_cnt), 32'(cnt));
  endtask

  // Fire at 07:30:00 from ARMED; leaves the DUT in RING
  task automatic fire_at_0730();
    set_time(5'd7, 6'd30, 6'd0);
    tick_sec = 1'b1;
    step();
    tick_sec = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_sec = 1'b0; real_quarter = 1'b0;
    stop = 1'b0; snooze = 1'b0;
    alarm_hours = 5'd24; alarm_minutes = 6'd0;
    set_time(5'd7, 6'd0, 6'd0);
    step(); step();
    reset = 1'b0;
    step();
    // Reset / no-alarm state
    check_outs("reset", 1'b0, 1'b0, 2'd0);
    check("reset.buzz", 32'(buzz), 32'd0);
    check("reset.state", 32'(dut.state_q), 32'(ST_IDLE));

    // Arm 07:30
    alarm_hours = 5'd7; alarm_minutes = 6'd30;
    step();
    check("arm.state", 32'(dut.state_q), 32'(ST_ARMED));
    set_time(5'd7, 6'd29, 6'd59);
    tick_pulse();
    check("0729_59.ringing", 32'(ringing), 32'd0);
    // 07:30:00 without a tick does not fire
    set_time(5'd7, 6'd30, 6'd0);
    step();
    check("notick.ringing", 32'(ringing), 32'd0);
    tick_sec = 1'b1;
    #1;
    check("fire_edge.ringing", 32'(ringing), 32'd0);
    step();
    tick_sec = 1'b0;
    check("fire.ringing", 32'(ringing), 32'd1);
    check("fire.buzz_lo", 32'(buzz), 32'd0);
    real_quarter = 1'b1;
    #1;
    check("fire.buzz_hi", 32'(buzz), 32'd1);
    real_quarter = 1'b0;

    // Auto-timeout: 59 ticks keep ringing, the 60th stops it
    for (int i = 0; i < 59; i++) tick_pulse();
    check("tick59.ringing", 32'(ringing), 32'd1);
    tick_sec = 1'b1;
    step();
    tick_sec = 1'b0;
    check_outs("timeout", 1'b0, 1'b0, 2'd0);
    step(); step();
    check("timeout.state", 32'(dut.state_q), 32'(ST_HOLD));
    set_time(5'd7, 6'd31, 6'd0);
    step();
    check("hold_exit.state", 32'(dut.state_q), 32'(ST_ARMED));

    // Snooze three times, fourth press acts as stop
    fire_at_0730();
    check("s_fire.ringing", 32'(ringing), 32'd1);
    for (int n = 1; n <= 3; n++) begin
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      check_outs($sformatf("snooze%0d", n), 1'b0, 1'b1, 2'(n));
      for (int i = 0; i < 299; i++) tick_pulse();
      check($sformatf("snooze%0d_299.snoozing", n), 32'(snoozing), 32'd1);
      tick_sec = 1'b1;
      step();
      tick_sec = 1'b0;
      check_outs($sformatf("rering%0d", n), 1'b1, 1'b0, 2'(n));
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check_outs("snooze4", 1'b0, 1'b0, 2'd3);
    check("snooze4.state", 32'(dut.state_q), 32'(ST_HOLD));
    set_time(5'd7, 6'd31, 6'd0);
    step();
    check("snooze4_rearm.state", 32'(dut.state_q), 32'(ST_ARMED));
    check("snooze4_rearm.cnt", 32'(snooze_cnt), 32'd0);

    // stop and snooze together: stop wins
    fire_at_0730();
    stop = 1'b1; snooze = 1'b1;
    step();
    stop = 1'b0; snooze = 1'b0;
    check_outs("stop_snooze", 1'b0, 1'b0, 2'd0);
    check("stop_snooze.state", 32'(dut.state_q), 32'(ST_HOLD));
    set_time(5'd7, 6'd30, 6'd1);
    step();
    check("stop_rearm.state", 32'(dut.state_q), 32'(ST_ARMED));

    // Setpoint change while armed acts immediately
    alarm_hours = 5'd8; alarm_minutes = 6'd15;
    fire_at_0730();
    check("old_setpoint.ringing", 32'(ringing), 32'd0);
    set_time(5'd8, 6'd15, 6'd0);
    tick_sec = 1'b1;
    step();
    tick_sec = 1'b0;
    check("new_setpoint.ringing", 32'(ringing), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    set_time(5'd8, 6'd16, 6'd0);
    step();

    // Out-of-range setpoint never fires
    alarm_hours = 5'd7; alarm_minutes = 6'd61;
    set_time(5'd7, 6'd61, 6'd0);
    tick_pulse();
    check("out_of_range.ringing", 32'(ringing), 32'd0);
    alarm_minutes = 6'd30;
    step();

    // Clearing the setpoint during SNOOZE aborts the event
    fire_at_0730();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("clr_pre.snoozing", 32'(snoozing), 32'd1);
    alarm_hours = 5'd24;
    step();
    check_outs("clear", 1'b0, 1'b0, 2'd0);
    check("clear.state", 32'(dut.state_q), 32'(ST_IDLE));
    set_time(5'd7, 6'd31, 6'd0);
    step();
    fire_at_0730();
    step();
    check("clear_0730.ringing", 32'(ringing), 32'd0);

    // Reset mid-ring silences, then the alarm fires again next day
    alarm_hours = 5'd7; alarm_minutes = 6'd30;
    set_time(5'd7, 6'd29, 6'd0);
    step(); step();
    fire_at_0730();
    check("pre_reset.ringing", 32'(ringing), 32'd1);
    real_quarter = 1'b1;
    reset = 1'b1;
    set_time(5'd7, 6'd30, 6'd1);
    step();
    reset = 1'b0;
    check_outs("mid_reset", 1'b0, 1'b0, 2'd0);
    check("mid_reset.buzz", 32'(buzz), 32'd0);
    step(); step();
    check("post_reset.state", 32'(dut.state_q), 32'(ST_ARMED));
    set_time(5'd7, 6'd29, 6'd59);
    tick_pulse();
    fire_at_0730();
    check("next_day.ringing", 32'(ringing), 32'd1);
    check("next_day.buzz", 32'(buzz), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
